pipe_seq: RTL and testbench

- Parametrised multi-cycle pipeline sequencer: owns the run-mode FSM (STALL/LOAD/EXEC/HALT), the stage walker (FETCH/DECODE/EXECUTE/WRITEREG), the PC register and all inter-stage register update strobes.
- Next generation of the core's top-level control. Adds configurable stage latencies, sticky boot handshakes, an external hold, a restart path out of HALT, and a retire pulse.
- Sits between the loader/UART boot logic and the fdreg/dereg/ewreg/execute datapath.

---
 rtl/pipe_seq_pkg.sv | 23 ++
 rtl/pipe_seq_stage_timer.sv | 29 ++
 rtl/pipe_seq.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared encodings and default latencies for the pipeline sequencer.
package pipe_seq_pkg;

  // Run mode of the core, visible on the mode output.
  typedef enum logic [1:0] {
    MODE_STALL = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_EXEC  = 2'd2,
    MODE_HALT  = 2'd3
  } mode_t;

  // Stage the walker is in, visible on the pipe output.
  typedef enum logic [1:0] {
    PIPE_FETCH    = 2'd0,
    PIPE_DECODE   = 2'd1,
    PIPE_EXECUTE  = 2'd2,
    PIPE_WRITEREG = 2'd3
  } pipe_t;

  localparam int DEF_EXEC_LAT = 5;
  localparam int DEF_WB_LAT   = 2;

endpackage

// File: rtl/pipe_seq_stage_timer.sv
// Loadable down-counter shared by EXECUTE and WRITEREG. A load wins over a
// count; counting stops at zero, so a stage that must wait past its minimum
// length sits with done=1 until the walker moves on.
module pipe_seq_stage_timer #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             en,
  output logic [LAT_W-1:0] cnt,
  output logic             done
);

  // Load a fresh stage length, or count down towards zero and stay there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pipe_seq.sv
// Top-level control of the core: run-mode FSM, stage walker, PC register
// and the registered inter-stage update strobes.
// Optional build macro PIPE_SEQ_PERF_EN adds the cyc_cnt/ret_cnt counters.
//
// Boot handshake: boot_req is a one-cycle request honoured only in STALL.
// In LOAD, load_done (level) and boot_ack (pulse or level) are each caught
// in a sticky flag; once both have been seen the core enters EXEC on the
// next edge and the flags clear. There is no back-pressure toward the host.
module pipe_seq
  import pipe_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              EXEC_LAT = DEF_EXEC_LAT,
  parameter int              WB_LAT   = DEF_WB_LAT,
  parameter int              LAT_W    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            boot_req,
  input  logic            load_done,
  input  logic            boot_ack,
  input  logic            hold,
  input  logic            restart,
  input  logic            e_busy,
  input  logic [PC_W-1:0] e_npc,
  input  logic            de_stop,
  output logic [1:0]      mode,
  output logic [1:0]      pipe,
  output logic [PC_W-1:0] pc,
  output logic            fd_upd,
  output logic            de_upd,
  output logic            ew_upd,
  output logic            e_start,
  output logic            retire
`ifdef PIPE_SEQ_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     ret_cnt
`endif
);

  if (EXEC_LAT < 1 || WB_LAT < 1 ||
      EXEC_LAT >= (1 << LAT_W) || WB_LAT >= (1 << LAT_W)) begin : g_bad_lat
    $error("pipe_seq: EXEC_LAT and WB_LAT must be >= 1 and < 2**LAT_W");
  end

  mode_t            mode_q;
  pipe_t            pipe_q;
  logic             ld_flag;
  logic             ack_flag;
  logic             t_load;
  logic [LAT_W-1:0] t_val;
  logic             t_en;
  logic [LAT_W-1:0] t_cnt;
  logic             t_done;
  logic             in_exec;
  logic             exec_last;
  logic             wb_last;
  logic             boot_ok;
  logic             retire_nxt;

  assign in_exec   = (mode_q == MODE_EXEC);
  // Final EXECUTE cycle: minimum length reached and the unit is free.
  assign exec_last = in_exec && (pipe_q == PIPE_EXECUTE) && t_done && !e_busy;
  assign wb_last   = in_exec && (pipe_q == PIPE_WRITEREG) && t_done;
  assign boot_ok   = (ld_flag || load_done) && (ack_flag || boot_ack);
  // retire is registered, so it is raised on the edge that enters the last
  // WRITEREG cycle.
  assign retire_nxt = (exec_last && (WB_LAT == 1)) ||
                      (in_exec && (pipe_q == PIPE_WRITEREG) && (t_cnt == LAT_W'(1)));

  pipe_seq_stage_timer #(.LAT_W(LAT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .cnt      (t_cnt),
    .done     (t_done)
  );

  // Timer control: arm for EXECUTE out of DECODE, for WRITEREG out of EXECUTE.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    t_en   = 1'b0;
    if (in_exec) begin
      if (pipe_q == PIPE_DECODE) begin
        t_load = 1'b1;
        t_val  = LAT_W'(EXEC_LAT - 1);
      end else if (exec_last) begin
        t_load = 1'b1;
        t_val  = LAT_W'(WB_LAT - 1);
      end else if (pipe_q == PIPE_EXECUTE || pipe_q == PIPE_WRITEREG) begin
        t_en = 1'b1;
      end
    end
  end

  // Mode FSM, stage walker, PC and registered strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= MODE_STALL;
      pipe_q   <= PIPE_FETCH;
      pc       <= RESET_PC;
      ld_flag  <= 1'b0;
      ack_flag <= 1'b0;
      fd_upd   <= 1'b0;
      de_upd   <= 1'b0;
      ew_upd   <= 1'b0;
      e_start  <= 1'b0;
      retire   <= 1'b0;
    end else begin
      fd_upd  <= 1'b0;
      de_upd  <= 1'b0;
      ew_upd  <= 1'b0;
      e_start <= 1'b0;
      retire  <= retire_nxt;
      case (mode_q)
        MODE_STALL: begin
          if (boot_req) mode_q <= MODE_LOAD;
        end
        MODE_LOAD: begin
          if (boot_ok) begin
            mode_q   <= MODE_EXEC;
            pipe_q   <= PIPE_FETCH;
            ld_flag  <= 1'b0;
            ack_flag <= 1'b0;
            fd_upd   <= !hold;
          end else begin
            ld_flag  <= ld_flag || load_done;
            ack_flag <= ack_flag || boot_ack;
          end
        end
        MODE_EXEC: begin
          case (pipe_q)
            PIPE_FETCH: begin
              // fd_upd high marks a real fetch cycle; low means parked on hold.
              if (fd_upd) begin
                pipe_q <= PIPE_DECODE;
                de_upd <= 1'b1;
              end else begin
                fd_upd <= !hold;
              end
            end
            PIPE_DECODE: begin
              pipe_q  <= PIPE_EXECUTE;
              e_start <= 1'b1;
            end
            PIPE_EXECUTE: begin
              if (exec_last) begin
                pc     <= e_npc;
                pipe_q <= PIPE_WRITEREG;
                ew_upd <= 1'b1;
              end
            end
            default: begin
              if (wb_last) begin
                if (de_stop) begin
                  mode_q <= MODE_HALT;
                end else begin
                  pipe_q <= PIPE_FETCH;
                  fd_upd <= !hold;
                end
              end
            end
          endcase
        end
        default: begin
          if (restart) begin
            mode_q <= MODE_STALL;
            pipe_q <= PIPE_FETCH;
            pc     <= RESET_PC;
          end
        end
      endcase
    end
  end

  assign mode = mode_q;
  assign pipe = pipe_q;

`ifdef PIPE_SEQ_PERF_EN
  // Cycles spent in EXEC and retired instructions; both clear when HALT is left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (mode_q == MODE_HALT && restart) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (in_exec) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)  ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_seq.sv
// Bench for pipe_seq: boot orderings, randomized instruction streams with
// busy stretches, holds and stray restarts, stop/restart, and async reset.
module tb_pipe_seq;

  localparam int          PC_W     = 32;
  localparam int          EXEC_LAT = 5;
  localparam int          WB_LAT   = 2;
  localparam logic [31:0] RST_PC   = 32'h100;
  localparam int          MAXC     = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        boot_req = 1'b0, load_done = 1'b0, boot_ack = 1'b0, hold = 1'b0;
  logic        restart = 1'b0, e_busy = 1'b0, de_stop = 1'b0;
  logic [31:0] e_npc = '0;
  logic [1:0]  mode, pipe;
  logic [31:0] pc;
  logic        fd_upd, de_upd, ew_upd, e_start, retire;
`ifdef PIPE_SEQ_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int nvec = 0;
  int nerr = 0;
  int cur  = 0;

  // Stimulus and expectation tables for one instruction segment.
  bit          in_busy[MAXC], in_hold[MAXC], in_stop[MAXC], in_rst[MAXC], in_breq[MAXC];
  logic [31:0] in_npc[MAXC], exp_pc[MAXC];
  bit          exp_fd[MAXC], exp_de[MAXC], exp_ew[MAXC], exp_es[MAXC], exp_ret[MAXC];
  bit          exp_pchk[MAXC];
  logic [1:0]  exp_mode[MAXC], exp_pipe[MAXC];
  logic [31:0] exp_q[$];
  int          seg_len, abort_cyc;
  logic [31:0] model_pc = RST_PC;
  int          model_cyc = 0, model_ret = 0;

  pipe_seq #(
    .PC_W(PC_W), .RESET_PC(RST_PC), .EXEC_LAT(EXEC_LAT), .WB_LAT(WB_LAT), .LAT_W(4)
  ) dut (
    .clk(clk), .rstn(rstn), .boot_req(boot_req), .load_done(load_done),
    .boot_ack(boot_ack), .hold(hold), .restart(restart), .e_busy(e_busy),
    .e_npc(e_npc), .de_stop(de_stop), .mode(mode), .pipe(pipe), .pc(pc),
    .fd_upd(fd_upd), .de_upd(de_upd), .ew_upd(ew_upd), .e_start(e_start),
    .retire(retire)
`ifdef PIPE_SEQ_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cur, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_pipe"}, pipe, 0);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_strobes"}, {fd_upd, de_upd, ew_upd, e_start, retire}, 0);
`ifdef PIPE_SEQ_PERF_EN
    check({tag, "_cyc_cnt"}, cyc_cnt, 0);
    check({tag, "_ret_cnt"}, ret_cnt, 0);
`endif
  endtask

  // Behavioural model: lay out each instruction's stages on a cycle timeline.
  task automatic build_segment(input int n, input bit stop, input int abort_i);
    int c, s, bs, bl, x, w, r, g;
    bit is_last;
    for (int k = 0; k < MAXC; k++) begin
      in_busy[k] = 1'($urandom_range(0, 1));
      in_hold[k] = ($urandom_range(0, 3) == 0);
      in_stop[k] = 1'($urandom_range(0, 1));
      in_rst[k]  = ($urandom_range(0, 7) == 0);
      in_breq[k] = ($urandom_range(0, 7) == 0);
      in_npc[k]  = $urandom;
      exp_fd[k] = 0; exp_de[k] = 0; exp_ew[k] = 0; exp_es[k] = 0; exp_ret[k] = 0;
      exp_pchk[k] = 1; exp_mode[k] = 2'd2; exp_pipe[k] = 2'd0; exp_pc[k] = '0;
    end
    c = 0;
    abort_cyc = -1;
    for (int i = 0; i < n; i++) begin
      s = c;
      is_last = (i == n - 1);
      exp_fd[s] = 1; exp_pipe[s] = 2'd0; exp_pc[s] = model_pc;
      exp_de[s+1] = 1; exp_pipe[s+1] = 2'd1; exp_pc[s+1] = model_pc;
      exp_es[s+2] = 1;
      // Busy window in execute-cycle terms; pc commits on the first cycle at
      // or past EXEC_LAT-1 that is outside the window.
      bs = $urandom_range(0, EXEC_LAT + 1);
      bl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      x = EXEC_LAT - 1;
      while (x >= bs && x < bs + bl) x++;
      for (int k = 0; k <= x; k++) begin
        in_busy[s+2+k]  = (k >= bs && k < bs + bl);
        exp_pipe[s+2+k] = 2'd2;
        exp_pc[s+2+k]   = model_pc;
      end
      model_pc = in_npc[s+2+x];
      w = s + 3 + x;
      r = w + WB_LAT - 1;
      for (int k = w; k <= r; k++) begin
        exp_pipe[k] = 2'd3;
        exp_pc[k]   = model_pc;
      end
      exp_ew[w] = 1;
      exp_ret[r] = 1;
      exp_q.push_back(model_pc);
      if (i == abort_i) abort_cyc = w;
      in_stop[r] = is_last && stop;
      g = (is_last || $urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 3);
      for (int k = 0; k < g; k++) begin
        in_hold[r+k]    = 1;
        exp_pipe[r+1+k] = 2'd0;
        exp_pc[r+1+k]   = model_pc;
      end
      in_hold[r+g] = 0;
      c = r + g + 1;
      if (is_last && stop) begin
        for (int k = r + 1; k <= r + 4; k++) begin
          exp_mode[k] = 2'd3;
          exp_pchk[k] = 0;
          exp_pc[k]   = model_pc;
          in_rst[k]   = 0;
        end
        c = r + 5;
      end
    end
    seg_len = c;
  endtask

  // Drive one segment cycle by cycle and compare against the model timeline.
  task automatic run_segment(input int n, input bit stop, input int abort_i);
    logic [31:0] want;
    build_segment(n, stop, abort_i);
    for (int c = 0; c < seg_len; c++) begin
      @(posedge clk); #1;
      e_busy = in_busy[c]; hold = in_hold[c]; de_stop = in_stop[c];
      restart = in_rst[c]; boot_req = in_breq[c]; e_npc = in_npc[c];
      load_done = 1'($urandom_range(0, 1)); boot_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      cur = c;
      check("mode", mode, exp_mode[c]);
      if (exp_pchk[c]) check("pipe", pipe, exp_pipe[c]);
      check("pc", pc, exp_pc[c]);
      check("fd_upd", fd_upd, exp_fd[c]);
      check("de_upd", de_upd, exp_de[c]);
      check("ew_upd", ew_upd, exp_ew[c]);
      check("e_start", e_start, exp_es[c]);
      check("retire", retire, exp_ret[c]);
      if (retire) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("retire_pc", pc, want);
      end
      if (exp_mode[c] == 2'd2) model_cyc++;
      if (exp_ret[c]) model_ret++;
      if (c == abort_cyc) begin
        #2 rstn = 1'b0;
        #1 check_reset("abort");
        exp_q.delete();
        model_pc = RST_PC; model_cyc = 0; model_ret = 0;
        break;
      end
    end
    if (stop) begin
      check("retire_left", exp_q.size(), 0);
`ifdef PIPE_SEQ_PERF_EN
      check("cyc_cnt", cyc_cnt, model_cyc);
      check("ret_cnt", ret_cnt, model_ret);
`endif
    end
  endtask

  // Boot: boot_req in cycle 0, ack pulse at ack_d, load_done level from ld_d.
  task automatic boot(input int ack_d, input int ld_d);
    int lst;
    lst = (ack_d > ld_d) ? ack_d : ld_d;
    for (int c = 0; c <= lst; c++) begin
      @(posedge clk); #1;
      boot_req  = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      boot_ack  = (c == ack_d);
      load_done = (c >= ld_d);
      hold = 1'b0; restart = 1'($urandom_range(0, 1));
      e_busy = 1'($urandom_range(0, 1)); de_stop = 1'($urandom_range(0, 1)); e_npc = $urandom;
      @(negedge clk);
      cur = c;
      check("boot_mode", mode, (c == 0) ? 0 : 1);
      check("boot_fd", fd_upd, 0);
      check("boot_pc", pc, model_pc);
    end
  endtask

  task automatic do_restart();
    @(posedge clk); #1;
    restart = 1'b1; boot_req = 1'b0;
    @(negedge clk);
    check("halt_mode", mode, 3);
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_pipe", pipe, 0);
    check("rst_pc", pc, RST_PC);
`ifdef PIPE_SEQ_PERF_EN
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_ret_cnt", ret_cnt, 0);
`endif
    model_pc = RST_PC; model_cyc = 0; model_ret = 0;
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    // STALL ignores restart.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      restart = 1'b1; boot_req = 1'b0;
      @(negedge clk);
      check("stall_mode", mode, 0);
    end
    restart = 1'b0;

    boot(3, 10);
    run_segment(100, 1'b1, -1);
    do_restart();

    boot(10, 3);
    run_segment(5, 1'b1, -1);
    do_restart();

    boot(2, 2);
    run_segment(4, 1'b0, 2);
    @(posedge clk);
    #3 rstn = 1'b1;
    boot_req = 1'b0; restart = 1'b0; load_done = 1'b0; boot_ack = 1'b0;

    boot(1, 4);
    run_segment(3, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
